// File: rtl/generic_sram_axi4_pkg.sv
// Shared types and AXI4 encodings for the SRAM-style to AXI4 initiator bridge.
package generic_sram_axi4_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP
    } bridge_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    // AxSIZE encoding for a full-width beat: log2 of the bytes per beat.
    function automatic logic [2:0] axi_size(input int unsigned data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/generic_sram_byte_en_axi4_initiator_bridge.sv
// Turns byte-enable SRAM-style requests into single-beat AXI4 reads/writes,
// one transaction in flight, each finished by a one-cycle response pulse.
module generic_sram_byte_en_axi4_initiator_bridge
    import generic_sram_axi4_pkg::*;
#(
    parameter int unsigned MEM_ADDR_BITS     = 10,
    parameter int unsigned AXI_ADDRESS_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH    = 32,
    parameter int unsigned AXI_ID_WIDTH      = 4,
    parameter int unsigned AXI_ID            = 0,
    parameter int unsigned MEM_ADDR_OFFSET   = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,

    input  logic [MEM_ADDR_BITS-1:0]       addr,
    input  logic                           write_en,
    input  logic                           read_en,
    input  logic [AXI_DATA_WIDTH/8-1:0]    byte_en,
    input  logic [AXI_DATA_WIDTH-1:0]      write_data,
    output logic                           req_ready,
    output logic [AXI_DATA_WIDTH-1:0]      read_data,
    output logic                           rsp_valid,
    output logic                           rsp_err,

    output logic [AXI_ADDRESS_WIDTH-1:0]   AWADDR,
    output logic [AXI_ID_WIDTH-1:0]        AWID,
    output logic                           AWVALID,
    input  logic                           AWREADY,
    output logic [7:0]                     AWLEN,
    output logic [2:0]                     AWSIZE,
    output logic [1:0]                     AWBURST,
    output logic                           AWLOCK,
    output logic [3:0]                     AWCACHE,
    output logic [2:0]                     AWPROT,
    output logic [3:0]                     AWQOS,
    output logic [3:0]                     AWREGION,

    output logic [AXI_DATA_WIDTH-1:0]      WDATA,
    output logic [AXI_DATA_WIDTH/8-1:0]    WSTRB,
    output logic                           WLAST,
    output logic                           WVALID,
    input  logic                           WREADY,

    input  logic [AXI_ID_WIDTH-1:0]        BID,
    input  logic [1:0]                     BRESP,
    input  logic                           BVALID,
    output logic                           BREADY,

    output logic [AXI_ADDRESS_WIDTH-1:0]   ARADDR,
    output logic [AXI_ID_WIDTH-1:0]        ARID,
    output logic                           ARVALID,
    input  logic                           ARREADY,
    output logic [7:0]                     ARLEN,
    output logic [2:0]                     ARSIZE,
    output logic [1:0]                     ARBURST,
    output logic                           ARLOCK,
    output logic [3:0]                     ARCACHE,
    output logic [2:0]                     ARPROT,
    output logic [3:0]                     ARQOS,
    output logic [3:0]                     ARREGION,

    input  logic [AXI_ID_WIDTH-1:0]        RID,
    input  logic [AXI_DATA_WIDTH-1:0]      RDATA,
    input  logic [1:0]                     RRESP,
    input  logic                           RLAST,
    input  logic                           RVALID,
    output logic                           RREADY
);

    localparam int unsigned STRB_WIDTH     = AXI_DATA_WIDTH / 8;
    localparam int unsigned ADDR_WIDTH_OFF = $clog2(STRB_WIDTH);
    localparam logic [MEM_ADDR_BITS-1:0] OFFSET_WORDS = MEM_ADDR_BITS'(MEM_ADDR_OFFSET);
    localparam logic [AXI_ID_WIDTH-1:0]  ID_VAL       = AXI_ID_WIDTH'(AXI_ID);

    bridge_state_e                 state_q, state_d;
    logic                          aw_done_q, aw_done_d;
    logic                          w_done_q, w_done_d;
    logic                          req_ready_q, req_ready_d;
    logic                          awvalid_q, awvalid_d;
    logic                          wvalid_q, wvalid_d;
    logic                          arvalid_q, arvalid_d;
    logic                          bready_q, bready_d;
    logic                          rready_q, rready_d;
    logic                          rsp_valid_q, rsp_valid_d;
    logic                          rsp_err_q, rsp_err_d;
    logic [AXI_DATA_WIDTH-1:0]     read_data_q, read_data_d;
    logic [AXI_ADDRESS_WIDTH-1:0]  awaddr_q, awaddr_d;
    logic [AXI_ADDRESS_WIDTH-1:0]  araddr_q, araddr_d;
    logic [AXI_DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]         wstrb_q, wstrb_d;

    logic [MEM_ADDR_BITS-1:0]      word_addr;
    logic [AXI_ADDRESS_WIDTH-1:0]  byte_addr;

    // The word sum wraps at 2^MEM_ADDR_BITS before widening to a byte address.
    always_comb begin
        word_addr = addr + OFFSET_WORDS;
        byte_addr = AXI_ADDRESS_WIDTH'(word_addr) << ADDR_WIDTH_OFF;
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of its neighbours; blocking here would create order races.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            req_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            // NOTE: the data/address holding registers are cleared as well, so
            // the AXI payload and read_data never show stale values after reset.
            read_data_q <= '0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
        end else begin
            state_q     <= state_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            req_ready_q <= req_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            read_data_q <= read_data_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_d     = state_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        read_data_d = read_data_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;

        case (state_q)
            ST_IDLE: begin
                // req_ready_q gates acceptance so nothing is taken the cycle reset lifts.
                if (req_ready_q && write_en) begin
                    awaddr_d  = byte_addr;
                    wdata_d   = write_data;
                    wstrb_d   = byte_en;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_WR_REQ;
                end else if (req_ready_q && read_en) begin
                    araddr_d  = byte_addr;
                    arvalid_d = 1'b1;
                    state_d   = ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                if (awvalid_q && AWREADY) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && WREADY) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    bready_d  = 1'b1;
                    state_d   = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (BVALID) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = (BRESP != AXI_RESP_OKAY) || (BID != ID_VAL);
                    state_d     = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                if (RVALID) begin
                    rready_d    = 1'b0;
                    read_data_d = RDATA;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = (RRESP != AXI_RESP_OKAY) || (RID != ID_VAL) || !RLAST;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    // Simultaneous read and write is an illegal use of the port; the write wins.
    always_ff @(posedge clk) begin
        if (rst_n && state_q == ST_IDLE && req_ready_q) begin
            assert (!(write_en && read_en));
        end
    end

    assign req_ready = req_ready_q;
    assign read_data = read_data_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;

    assign AWADDR   = awaddr_q;
    assign AWID     = ID_VAL;
    assign AWVALID  = awvalid_q;
    assign AWLEN    = 8'h00;
    assign AWSIZE   = axi_size(AXI_DATA_WIDTH);
    assign AWBURST  = AXI_BURST_INCR;
    assign AWLOCK   = 1'b0;
    assign AWCACHE  = 4'h0;
    assign AWPROT   = 3'h0;
    assign AWQOS    = 4'h0;
    assign AWREGION = 4'h0;

    assign WDATA    = wdata_q;
    assign WSTRB    = wstrb_q;
    assign WLAST    = 1'b1;
    assign WVALID   = wvalid_q;
    assign BREADY   = bready_q;

    assign ARADDR   = araddr_q;
    assign ARID     = ID_VAL;
    assign ARVALID  = arvalid_q;
    assign ARLEN    = 8'h00;
    assign ARSIZE   = axi_size(AXI_DATA_WIDTH);
    assign ARBURST  = AXI_BURST_INCR;
    assign ARLOCK   = 1'b0;
    assign ARCACHE  = 4'h0;
    assign ARPROT   = 3'h0;
    assign ARQOS    = 4'h0;
    assign ARREGION = 4'h0;
    assign RREADY   = rready_q;

endmodule
